// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits 32-bit pipeline loads/stores into two 16-bit beats
// on an asynchronous SRAM, holding ready low to freeze the pipeline while busy.
module sram_mem_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_en,
   input  logic        i_rd_en,
   input  logic [31:0] i_address,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data,
   output logic        o_ready,
   output logic [17:0] o_sram_addr,
   output logic [15:0] o_sram_dq_out,
   input  logic [15:0] i_sram_dq_in,
   output logic        o_sram_dq_oe,
   output logic        o_sram_we_n,
   output logic        o_sram_oe_n
);

   localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntReload = CntW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic            r_is_write;
   logic [16:0]     r_idx;
   logic [31:0]     r_wdata;
   logic [15:0]     r_low_half;
   logic [31:0]     r_read_data;

   logic            w_req;
   logic            w_accept;
   logic            w_last;
   logic            w_beat;
   logic [16:0]     w_idx;

   assign w_req    = i_wr_en | i_rd_en;
   assign w_accept = (r_state == StIdle) && w_req;
   assign w_last   = (r_cnt == '0);
   // Addresses below BASE_ADDR wrap silently within the 17-bit word space.
   assign w_idx    = 17'((i_address - BASE_ADDR) >> 2);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_req) begin
               w_state_next = StLow;
               w_cnt_next   = CntReload;
            end
         end
         StLow: begin
            if (w_last) begin
               w_state_next = StHigh;
               w_cnt_next   = CntReload;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         StHigh: begin
            if (w_last) begin
               w_state_next = StDone;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_is_write  <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_low_half  <= '0;
         r_read_data <= '0;
      end else begin
         if (w_accept) begin
            r_is_write <= i_wr_en;
            r_idx      <= w_idx;
            r_wdata    <= i_write_data;
         end
         if ((r_state == StLow) && w_last && !r_is_write) begin
            r_low_half <= i_sram_dq_in;
         end
         // Both halves land together so read_data never shows a mixed word.
         if ((r_state == StHigh) && w_last && !r_is_write) begin
            r_read_data <= {i_sram_dq_in, r_low_half};
         end
      end
   end

   assign w_beat        = (r_state == StLow) || (r_state == StHigh);
   assign o_ready       = ((r_state == StIdle) && !w_req) || (r_state == StDone);
   assign o_sram_addr   = {r_idx, r_state == StHigh};
   assign o_sram_dq_out = (r_state == StHigh) ? r_wdata[31:16] : r_wdata[15:0];
   assign o_sram_dq_oe  = w_beat && r_is_write;
   assign o_sram_we_n   = !(w_beat && r_is_write);
   assign o_sram_oe_n   = !(w_beat && !r_is_write);
   assign o_read_data   = r_read_data;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: main DUT at WAIT_CYCLES=2 and a second
// instance at WAIT_CYCLES=1 for back-to-back reads, each with a behavioural SRAM.
module tb_sram_mem_controller;

   logic        clk;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n, sram_oe_n;

   logic        b_wr_en, b_rd_en;
   logic [31:0] b_address, b_write_data, b_read_data;
   logic        b_ready;
   logic [17:0] b_sram_addr;
   logic [15:0] b_sram_dq_out, b_sram_dq_in;
   logic        b_sram_dq_oe, b_sram_we_n, b_sram_oe_n;

   logic [15:0] mem  [0:255];
   logic [15:0] mem1 [0:255];
   logic [17:0] log_addr [$];
   logic [15:0] log_data [$];

   int checks   = 0;
   int failures = 0;

   sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
      .i_address(address), .i_write_data(write_data), .o_read_data(read_data),
      .o_ready(ready), .o_sram_addr(sram_addr), .o_sram_dq_out(sram_dq_out),
      .i_sram_dq_in(sram_dq_in), .o_sram_dq_oe(sram_dq_oe), .o_sram_we_n(sram_we_n),
      .o_sram_oe_n(sram_oe_n)
   );

   sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(b_wr_en), .i_rd_en(b_rd_en),
      .i_address(b_address), .i_write_data(b_write_data), .o_read_data(b_read_data),
      .o_ready(b_ready), .o_sram_addr(b_sram_addr), .o_sram_dq_out(b_sram_dq_out),
      .i_sram_dq_in(b_sram_dq_in), .o_sram_dq_oe(b_sram_dq_oe), .o_sram_we_n(b_sram_we_n),
      .o_sram_oe_n(b_sram_oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign sram_dq_in   = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];
   assign b_sram_dq_in = b_sram_oe_n ? 16'h0000 : mem1[b_sram_addr[7:0]];

   always @(posedge clk) begin
      if (!sram_we_n) begin
         mem[sram_addr[7:0]] <= sram_dq_out;
         if (log_addr.size() == 0 || log_addr[$] != sram_addr || log_data[$] != sram_dq_out) begin
            log_addr.push_back(sram_addr);
            log_data.push_back(sram_dq_out);
         end
      end
   end

   // One access on the main DUT; request inputs are scrambled after cycle 0.
   task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, output int low,
                            output logic [31:0] rdata, output int strobe_err,
                            output logic [17:0] beat_addr);
      int   n;
      logic exp_we_n, exp_oe_n;
      exp_we_n = !wr;
      exp_oe_n = !(rd && !wr);
      @(negedge clk);
      wr_en = wr; rd_en = rd; address = addr; write_data = data;
      #1;
      low = 0; strobe_err = 0; n = 0; beat_addr = '0;
      while (ready !== 1'b1 && n < 40) begin
         if (n == 0) begin
            if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) strobe_err++;
         end else begin
            if (sram_we_n !== exp_we_n || sram_oe_n !== exp_oe_n || sram_dq_oe !== wr)
               strobe_err++;
         end
         if (n == 1) beat_addr = sram_addr;
         low++;
         @(negedge clk);
         wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
         #1;
         n++;
      end
      if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) strobe_err++;
      rdata = read_data;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
      checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
      checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b exp=1", sram_oe_n); end
      checks++; if (sram_dq_oe !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b exp=0", sram_dq_oe); end
      checks++; if (sram_addr !== 18'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
      rd_en = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_req got=%b exp=0", ready); end
      rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write();
      int low, serr; logic [31:0] rdata; logic [17:0] baddr;
      log_addr.delete(); log_data.delete();
      do_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, low, rdata, serr, baddr);
      checks++; if (low != 5) begin failures++; $display("FAIL write_ready_low got=%0d exp=5", low); end
      checks++; if (serr != 0) begin failures++; $display("FAIL write_strobes got=%0d errs exp=0", serr); end
      checks++; if (baddr !== 18'd0) begin failures++; $display("FAIL write_beat_addr got=%h exp=0", baddr); end
      checks++;
      if (log_addr.size() != 2 || log_addr[0] !== 18'd0 || log_data[0] !== 16'hBEEF ||
          log_addr[1] !== 18'd1 || log_data[1] !== 16'hDEAD) begin
         failures++;
         $display("FAIL write_order got n=%0d first=%h:%h exp 0:beef then 1:dead", log_addr.size(),
                  (log_addr.size() > 0) ? log_addr[0] : 18'h0, (log_data.size() > 0) ? log_data[0] : 16'h0);
      end
      @(negedge clk); #1;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL write_post_idle got=%b exp=1", ready); end
   endtask

   task automatic test_read_back_priority();
      int low, serr; logic [31:0] rdata; logic [17:0] baddr;
      do_access(1'b0, 1'b1, 32'd1024, 32'h0, low, rdata, serr, baddr);
      checks++; if (low != 5) begin failures++; $display("FAIL read_ready_low got=%0d exp=5", low); end
      checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", rdata); end
      checks++; if (serr != 0) begin failures++; $display("FAIL read_strobes got=%0d errs exp=0", serr); end
      log_addr.delete(); log_data.delete();
      do_access(1'b1, 1'b1, 32'd1044, 32'h1234_5678, low, rdata, serr, baddr);
      checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=deadbeef", rdata); end
      checks++; if (serr != 0) begin failures++; $display("FAIL prio_strobes got=%0d errs exp=0", serr); end
      checks++; if (baddr !== 18'd10) begin failures++; $display("FAIL prio_beat_addr got=%0d exp=10", baddr); end
      checks++;
      if (mem[10] !== 16'h5678 || mem[11] !== 16'h1234) begin
         failures++; $display("FAIL prio_mem got=%h_%h exp=1234_5678", mem[11], mem[10]);
      end
      do_access(1'b0, 1'b1, 32'd1044, 32'h0, low, rdata, serr, baddr);
      checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL read_1044 got=%h exp=12345678", rdata); end
   endtask

   task automatic test_reset_mid_write();
      int low, serr; logic [31:0] rdata; logic [17:0] baddr;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1048; write_data = 32'hAAAA_5555;
      @(negedge clk); wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if (sram_we_n !== 1'b0 || sram_addr !== 18'd13) begin
         failures++; $display("FAIL midw_high_beat got we_n=%b addr=%0d exp 0/13", sram_we_n, sram_addr);
      end
      rst = 1'b1;
      #1;
      checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL midw_we_n got=%b exp=1", sram_we_n); end
      checks++; if (sram_dq_oe !== 1'b0) begin failures++; $display("FAIL midw_dq_oe got=%b exp=0", sram_dq_oe); end
      checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL midw_read_data got=%h exp=0", read_data); end
      checks++; if (sram_addr !== 18'h0) begin failures++; $display("FAIL midw_addr got=%h exp=0", sram_addr); end
      @(negedge clk);
      rst = 1'b0;
      do_access(1'b0, 1'b1, 32'd1024, 32'h0, low, rdata, serr, baddr);
      checks++; if (low != 5) begin failures++; $display("FAIL midw_restart_low got=%0d exp=5", low); end
      checks++; if (baddr !== 18'd0) begin failures++; $display("FAIL midw_restart_addr got=%h exp=0", baddr); end
      checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL midw_restart_data got=%h exp=deadbeef", rdata); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      b_rd_en = 1'b1; b_address = 32'd1032;
      #1;
      checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL b2b_c0_ready got=%b exp=0", b_ready); end
      @(negedge clk);
      b_address = 32'd1040;
      #1;
      checks++;
      if (b_ready !== 1'b0 || b_sram_addr !== 18'd4 || b_sram_oe_n !== 1'b0) begin
         failures++; $display("FAIL b2b_c1 got ready=%b addr=%0d oe_n=%b exp 0/4/0", b_ready, b_sram_addr, b_sram_oe_n);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b0 || b_sram_addr !== 18'd5) begin
         failures++; $display("FAIL b2b_c2 got ready=%b addr=%0d exp 0/5", b_ready, b_sram_addr);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b1 || b_read_data !== 32'h2222_1111) begin
         failures++; $display("FAIL b2b_done1 got ready=%b data=%h exp 1/22221111", b_ready, b_read_data);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b0 || b_read_data !== 32'h2222_1111) begin
         failures++; $display("FAIL b2b_c4 got ready=%b data=%h exp 0/22221111", b_ready, b_read_data);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b0 || b_sram_addr !== 18'd8 || b_sram_oe_n !== 1'b0) begin
         failures++; $display("FAIL b2b_c5 got ready=%b addr=%0d oe_n=%b exp 0/8/0", b_ready, b_sram_addr, b_sram_oe_n);
      end
      b_address = 32'd1060; b_rd_en = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b0 || b_sram_addr !== 18'd9) begin
         failures++; $display("FAIL b2b_c6 got ready=%b addr=%0d exp 0/9", b_ready, b_sram_addr);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b1 || b_read_data !== 32'h4444_3333) begin
         failures++; $display("FAIL b2b_done2 got ready=%b data=%h exp 1/44443333", b_ready, b_read_data);
      end
      @(negedge clk); #1;
      checks++;
      if (b_ready !== 1'b1 || b_sram_oe_n !== 1'b1) begin
         failures++; $display("FAIL b2b_idle got ready=%b oe_n=%b exp 1/1", b_ready, b_sram_oe_n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_address = '0; b_write_data = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 16'h0;
         mem1[i] = 16'h0;
      end
      mem1[4] = 16'h1111; mem1[5] = 16'h2222;
      mem1[8] = 16'h3333; mem1[9] = 16'h4444;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_write();
      test_read_back_priority();
      test_reset_mid_write();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage controller that turns the pipeline's 32-bit load/store requests into two-beat accesses on an external 16-bit asynchronous SRAM. It sits between the EX/MEM pipeline register and the MEM/WB register. Load data it returns is carried to write-back and lands in the register file. While an access is in flight it deasserts `ready`; the hazard/freeze logic uses that to stall every upstream stage.

## Interface
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 2: clock cycles spent on each 16-bit beat; legal values are ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address of the access.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result.
- `ready`  out  1  low means freeze the pipeline.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  write data driven to the SRAM.
- `sram_dq_in`  in  16  read data returned by the SRAM.
- `sram_dq_oe`  out  1  enable for the top-level tristate of the data bus.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_oe_n`  out  1  SRAM output enable, active low.

## Operation
**States:** IDLE, LOW, HIGH, DONE. A `WAIT_CYCLES` down-counter runs in the LOW and HIGH states.

**IDLE**
- Accepts a request when `wr_en|rd_en` is high.
- If both are high, the access is a write.
- On the accepting edge it latches: op, word index = (`address` − `BASE_ADDR`) >> 2 (bits [16:0]), and `write_data`.
- Then moves to LOW with counter = `WAIT_CYCLES`−1.

**LOW**
- `sram_addr` = {idx, 1'b0}.
- Write: `sram_dq_oe`=1, `sram_dq_out`=wdata[15:0], `sram_we_n`=0.
- Read: `sram_oe_n`=0. On the final cycle (counter==0), `sram_dq_in` is captured into an internal low-half register.
- When counter==0, moves to HIGH and reloads the counter.

**HIGH**
- Same as LOW, with `sram_addr` = {idx, 1'b1} and wdata[31:16].
- Read: on the final cycle, `read_data` <= {`sram_dq_in`, low_half}. Both halves update on the same edge, so `read_data` never shows a mixed word.
- When counter==0, moves to DONE.

**DONE**
- Lasts one cycle, then returns to IDLE unconditionally.

**`ready`:** combinational; equals (IDLE && !`wr_en` && !`rd_en`) || DONE.

**SRAM outputs:** decoded from state. Outside LOW/HIGH: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0.

**Other rules**
- `read_data` holds its value except on the read-completion edge. Writes never change it.
- Request inputs, `address` and `write_data` are ignored outside IDLE. Changing or dropping them mid-access does not affect the latched transaction.
- Address bits [1:0] are ignored. Addresses below `BASE_ADDR` wrap modulo 2^17 words, with no error.

## Timing
**Reset.** While `rst` is high, with immediate effect independent of `clk`:
- state=IDLE, counter=0, `read_data`=0, low_half=0.
- Latched address and data = 0, so `sram_addr`=0 and `sram_dq_out`=0.
- `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0.
- `ready` = !(`wr_en`|`rd_en`).

**Reset mid-access.** The access is abandoned. No write is guaranteed to have completed in SRAM, and `read_data` = 0.

**Latency.** Call the cycle in which a request is seen in IDLE cycle 0.
- `ready` is low for cycles 0 … 2·`WAIT_CYCLES`.
- `ready` is high in cycle 2·`WAIT_CYCLES`+1 (DONE). With the default, `ready` is low for 5 cycles and high in cycle 5.
- `read_data` is valid from the start of DONE.

**Back-to-back.** If a request is still asserted in the cycle after DONE, it is treated as a new request: `ready` goes low again, and there are no idle SRAM cycles beyond the DONE cycle.

**Write beats.** Each write beat holds `sram_we_n` low for the whole beat, with address and data stable throughout. Address changes only at beat boundaries.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with no requests → `ready`=1, `read_data`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0.
- **Write:** `wr_en`, `address`=1024, `write_data`=0xDEADBEEF →
  - SRAM model gets 0xBEEF at halfword 0, then 0xDEAD at halfword 1.
  - `ready` low exactly 5 cycles, then high for 1.
- **Read back:** `rd_en`, `address`=1024 → `read_data`=0xDEADBEEF when `ready` rises. `read_data` is unchanged during a following write of 0x12345678 to 1044.
- **Address map and priority:** `wr_en`=`rd_en`=1 at `address`=1044 (byte offset 20 from `BASE_ADDR`) → treated as a write to halfwords 10 and 11. A read of 1044 then returns 0x12345678.
- **Reset during write:** assert `rst` during the HIGH beat → `sram_we_n`=1 and `sram_dq_oe`=0 immediately. After release, a request restarts from LOW.
- **Back-to-back, inputs moving:** hold `rd_en` high across two reads of different addresses, changing `address` mid-access → each read returns the data at the address latched in IDLE. The second access starts the cycle after DONE. `WAIT_CYCLES`=1 gives a `ready`-low span of 3 cycles.
